// File: rtl/rx_frame_packer.sv
// rx_frame_packer: packs length-prefixed radio frames into 16-bit words
// ({L,b0}, {b1,b2}, ...) and writes them into the receive SRAM FIFO.
// Optional statistics counters are enabled with `define RX_PACKER_STATS_EN.
module rx_frame_packer #(
  parameter int unsigned FIFO_DEPTH  = 2048,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        SRAM_write,
  input  logic        SRAM_hint,
  output logic [15:0] Data_to_sram,
  input  logic        SRAM_full,
  input  logic [10:0] SRAM_count,
  output logic        frame_recved_int,
  output logic [7:0]  drop_count,
  output logic [7:0]  pad_count
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_GET_HI, S_GET_LO, S_WR, S_WAIT_HINT, S_DONE, S_DROP, S_PAD
  } state_t;

  state_t        state, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    bytes_left, bytes_d;
  logic [8:0]    words_left, words_d;
  logic          pad_mode, pad_d;
  logic [TW-1:0] tmo_cnt, tmo_d;
  logic [15:0]   data_d;
  logic          write_d, ready_d, int_d;

  logic          accept, in_get, tmo_fire, fits;
  logic [8:0]    words_n;
  logic [11:0]   free_words;

  assign accept     = rx_valid && rx_ready;
  assign in_get     = (state == S_GET_HI) || (state == S_GET_LO);
  // An offered byte wins over a timeout firing in the same cycle
  assign tmo_fire   = in_get && !accept && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign words_n    = 9'((9'(len_q) + 9'd2) >> 1);
  assign free_words = 12'(FIFO_DEPTH) - {1'b0, SRAM_count};
  assign fits       = {3'b000, words_n} <= free_words;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      len_q            <= '0;
      bytes_left       <= '0;
      words_left       <= '0;
      pad_mode         <= 1'b0;
      tmo_cnt          <= '0;
      Data_to_sram     <= '0;
      SRAM_write       <= 1'b0;
      rx_ready         <= 1'b0;
      frame_recved_int <= 1'b0;
    end else begin
      state            <= state_d;
      len_q            <= len_d;
      bytes_left       <= bytes_d;
      words_left       <= words_d;
      pad_mode         <= pad_d;
      tmo_cnt          <= tmo_d;
      Data_to_sram     <= data_d;
      SRAM_write       <= write_d;
      rx_ready         <= ready_d;
      frame_recved_int <= int_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    len_d   = len_q;
    bytes_d = bytes_left;
    words_d = words_left;
    pad_d   = pad_mode;
    data_d  = Data_to_sram;
    write_d = SRAM_write;
    tmo_d   = '0;
    if (in_get && !accept) tmo_d = tmo_cnt + TW'(1);

    case (state)
      S_IDLE: begin
        pad_d = 1'b0;
        if (accept && (rx_byte != 8'h00)) begin
          len_d   = rx_byte;
          bytes_d = rx_byte;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        words_d = words_n;
        // The first word's high byte is the length itself, so go straight to the low half
        if (fits) begin
          data_d  = {len_q, 8'h00};
          state_d = S_GET_LO;
        end else begin
          state_d = S_DROP;
        end
      end
      S_GET_HI: begin
        if (accept) begin
          data_d  = {rx_byte, 8'h00};
          bytes_d = bytes_left - 8'd1;
          state_d = (bytes_left == 8'd1) ? S_WR : S_GET_LO;
        end else if (tmo_fire) begin
          data_d  = 16'h0000;
          pad_d   = 1'b1;
          state_d = S_PAD;
        end
      end
      S_GET_LO: begin
        if (accept) begin
          data_d  = {Data_to_sram[15:8], rx_byte};
          bytes_d = bytes_left - 8'd1;
          state_d = S_WR;
        end else if (tmo_fire) begin
          data_d  = {Data_to_sram[15:8], 8'h00};
          pad_d   = 1'b1;
          state_d = S_PAD;
        end
      end
      S_PAD: state_d = S_WR;
      S_WR: begin
        if (!SRAM_full) begin
          write_d = 1'b1;
          state_d = S_WAIT_HINT;
        end
      end
      S_WAIT_HINT: begin
        if (SRAM_hint) begin
          write_d = 1'b0;
          words_d = words_left - 9'd1;
          if (words_left > 9'd1) begin
            if (pad_mode) begin
              data_d  = 16'h0000;
              state_d = S_PAD;
            end else begin
              state_d = S_GET_HI;
            end
          end else begin
            state_d = pad_mode ? S_IDLE : S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      S_DROP: begin
        if (accept) begin
          bytes_d = bytes_left - 8'd1;
          if (bytes_left == 8'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    int_d   = (state == S_DONE);
    // Hold off the next length byte during the interrupt pulse
    ready_d = ((state_d == S_IDLE) || (state_d == S_DROP) ||
               (state_d == S_GET_HI) || (state_d == S_GET_LO)) && (state != S_DONE);
  end

`ifdef RX_PACKER_STATS_EN
  logic drop_inc, pad_inc;
  assign drop_inc = (state == S_DROP) && accept && (bytes_left == 8'd1);
  assign pad_inc  = (state == S_WAIT_HINT) && SRAM_hint && pad_mode && (words_left == 9'd1);

  // Saturating drop / pad statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_count <= '0;
      pad_count  <= '0;
    end else begin
      if (drop_inc && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
      if (pad_inc && (pad_count != 8'hFF))   pad_count  <= pad_count + 8'd1;
    end
  end
`else
  assign drop_count = 8'h00;
  assign pad_count  = 8'h00;
`endif

endmodule

// File: tb/tb_rx_frame_packer.sv
// Testbench for rx_frame_packer: frame-level word model, SRAM responder with
// per-cycle protocol/interrupt checks, and directed frames with literal words.
module tb_rx_frame_packer;

  localparam int unsigned DEPTH = 2048;
  localparam int unsigned TMO   = 40;
`ifdef RX_PACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        SRAM_write;
  logic        SRAM_hint = 1'b0;
  logic [15:0] Data_to_sram;
  logic        SRAM_full = 1'b0;
  logic [10:0] SRAM_count = 11'd0;
  logic        frame_recved_int;
  logic [7:0]  drop_count;
  logic [7:0]  pad_count;

  always #5 clk = ~clk;

  rx_frame_packer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .SRAM_write(SRAM_write), .SRAM_hint(SRAM_hint),
    .Data_to_sram(Data_to_sram), .SRAM_full(SRAM_full), .SRAM_count(SRAM_count),
    .frame_recved_int(frame_recved_int), .drop_count(drop_count), .pad_count(pad_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Frame-level model state
  logic [15:0] exp_q[$];
  bit          exp_last[$];
  logic [15:0] wlog[$];
  logic [7:0]  pay [0:255];
  int exp_pulses = 0, act_pulses = 0, exp_drops = 0, exp_pads = 0;
  int hint_delay = 1;
  logic full_at_edge = 1'b0;

  function automatic logic [15:0] get_w(input int idx);
    if (idx < wlog.size()) return wlog[idx];
    return 16'hxxxx;
  endfunction

  // Expected words: the stream {L, payload} zero-padded to 2*N bytes; bytes not
  // received before a timeout are zero. Dropped frames produce nothing.
  task automatic model_frame(input int len, input int n_sent);
    int nw;
    logic [7:0] s [0:511];
    if (len == 0) return;
    nw = (len + 2) / 2;
    if (int'(DEPTH) - int'(SRAM_count) < nw) begin
      exp_drops++;
      return;
    end
    s[0] = 8'(len);
    for (int i = 0; i < 2 * nw - 1; i++) s[i+1] = (i < n_sent) ? pay[i] : 8'h00;
    for (int w = 0; w < nw; w++) begin
      exp_q.push_back({s[2*w], s[2*w+1]});
      exp_last.push_back((w == nw - 1) && (n_sent >= len));
    end
    if (n_sent >= len) exp_pulses++;
    else exp_pads++;
  endtask

  // Full flag as the DUT sees it at each rising edge
  initial forever begin
    @(posedge clk);
    full_at_edge = SRAM_full;
  end

  // SRAM responder and per-cycle compare process
  initial begin
    int wcnt = 0;
    logic prev_write = 1'b0;
    logic [15:0] prev_data = 16'h0;
    logic [2:0] int_pipe = 3'b000;
    logic new_int;
    forever begin
      @(negedge clk);
      new_int = 1'b0;
      if (SRAM_hint) begin
        SRAM_hint = 1'b0;
        wcnt = 0;
      end else if (SRAM_write) begin
        if (wcnt >= hint_delay) begin
          wlog.push_back(Data_to_sram);
          chk("write_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
          if (exp_q.size() != 0) begin
            chk("word", Data_to_sram, exp_q[0]);
            new_int = exp_last[0];
            void'(exp_q.pop_front());
            void'(exp_last.pop_front());
          end
          SRAM_hint = 1'b1;
        end else begin
          wcnt++;
        end
      end
      if (SRAM_write && prev_write) chk("data_stable", Data_to_sram, prev_data);
      if (SRAM_write && !prev_write) chk("full_at_write_rise", full_at_edge, 1'b0);
      int_pipe = {int_pipe[1:0], new_int};
      chk("frame_int", frame_recved_int, int_pipe[2]);
      if (frame_recved_int) begin
        act_pulses++;
        chk("ready_low_during_int", rx_ready, 1'b0);
      end
      prev_write = SRAM_write;
      prev_data  = Data_to_sram;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_byte  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 1000) begin
      tick(1);
      n++;
    end
    chk("byte_accept_wait", (n < 1000) ? 32'd1 : 32'd0, 32'd1);
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int len, input int n_send);
    model_frame(len, n_send);
    send_byte(8'(len));
    for (int i = 0; i < n_send; i++) send_byte(pay[i]);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || SRAM_write || SRAM_hint) && n < 2000) begin
      tick(1);
      n++;
    end
    chk({name, "_drain"}, (n < 2000) ? 32'd1 : 32'd0, 32'd1);
    tick(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, p0;

    // Reset values
    tick(3);
    chk("rst_ready", rx_ready, 1'b0);
    chk("rst_write", SRAM_write, 1'b0);
    chk("rst_data", Data_to_sram, 16'h0);
    chk("rst_int", frame_recved_int, 1'b0);
    chk("rst_drop", drop_count, 8'h0);
    chk("rst_pad", pad_count, 8'h0);
    rst_n = 1'b1;
    chk("ready_before_rise", rx_ready, 1'b0);
    tick(1);
    chk("ready_after_reset", rx_ready, 1'b1);

    // L=3: A1 A2 A3
    base = wlog.size(); p0 = act_pulses;
    pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3;
    send_frame(3, 3);
    wait_drain("l3");
    chk("l3_nwords", wlog.size() - base, 2);
    chk("l3_w0", get_w(base), 16'h03A1);
    chk("l3_w1", get_w(base + 1), 16'hA2A3);
    chk("l3_pulses", act_pulses - p0, 1);

    // L=4: even length, last low byte zero
    hint_delay = 2;
    base = wlog.size(); p0 = act_pulses;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    send_frame(4, 4);
    wait_drain("l4");
    chk("l4_nwords", wlog.size() - base, 3);
    chk("l4_w0", get_w(base), 16'h0411);
    chk("l4_w1", get_w(base + 1), 16'h2233);
    chk("l4_w2", get_w(base + 2), 16'h4400);
    chk("l4_pulses", act_pulses - p0, 1);

    // L=1: single word
    hint_delay = 0;
    base = wlog.size(); p0 = act_pulses;
    pay[0] = 8'h5A;
    send_frame(1, 1);
    wait_drain("l1");
    chk("l1_nwords", wlog.size() - base, 1);
    chk("l1_w0", get_w(base), 16'h015A);
    chk("l1_pulses", act_pulses - p0, 1);

    // L=0: ignored
    hint_delay = 1;
    base = wlog.size(); p0 = act_pulses;
    send_byte(8'h00);
    chk("l0_ready_next", rx_ready, 1'b1);
    tick(6);
    chk("l0_ready", rx_ready, 1'b1);
    chk("l0_nwords", wlog.size() - base, 0);
    chk("l0_pulses", act_pulses - p0, 0);

    // L=200 with 98 free words: dropped
    base = wlog.size(); p0 = act_pulses;
    SRAM_count = 11'd1950;
    for (int i = 0; i < 200; i++) pay[i] = 8'(i * 7 + 3);
    send_frame(200, 200);
    wait_drain("drop");
    chk("drop_model", exp_drops, 1);
    chk("drop_nwords", wlog.size() - base, 0);
    chk("drop_pulses", act_pulses - p0, 0);
    chk("drop_count", drop_count, STATS ? 8'd1 : 8'd0);
    chk("drop_ready", rx_ready, 1'b1);
    SRAM_count = 11'd0;

    // L=5 truncated after 3 payload bytes: padded with zeros
    base = wlog.size(); p0 = act_pulses;
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    send_frame(5, 3);
    wait_drain("pad");
    chk("pad_model", exp_pads, 1);
    chk("pad_nwords", wlog.size() - base, 3);
    chk("pad_w0", get_w(base), 16'h0501);
    chk("pad_w1", get_w(base + 1), 16'h0203);
    chk("pad_w2", get_w(base + 2), 16'h0000);
    chk("pad_pulses", act_pulses - p0, 0);
    chk("pad_count", pad_count, STATS ? 8'd1 : 8'd0);

    // SRAM_full held for 10 cycles with a word pending
    base = wlog.size(); p0 = act_pulses;
    pay[0] = 8'hAB; pay[1] = 8'hCD;
    model_frame(2, 2);
    SRAM_full = 1'b1;
    send_byte(8'd2);
    send_byte(8'hAB);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("full_write_low", SRAM_write, 1'b0);
    end
    SRAM_full = 1'b0;
    tick(1);
    chk("full_write_rise", SRAM_write, 1'b1);
    send_byte(8'hCD);
    wait_drain("full");
    chk("full_w0", get_w(base), 16'h02AB);
    chk("full_w1", get_w(base + 1), 16'hCD00);
    chk("full_pulses", act_pulses - p0, 1);

    // Back-to-back frames
    base = wlog.size(); p0 = act_pulses;
    pay[0] = 8'h10; pay[1] = 8'h20;
    send_frame(2, 2);
    pay[0] = 8'h30; pay[1] = 8'h40; pay[2] = 8'h50;
    send_frame(3, 3);
    wait_drain("b2b");
    chk("b2b_w0", get_w(base), 16'h0210);
    chk("b2b_w1", get_w(base + 1), 16'h2000);
    chk("b2b_w2", get_w(base + 2), 16'h0330);
    chk("b2b_w3", get_w(base + 3), 16'h4050);
    chk("b2b_pulses", act_pulses - p0, 2);

    // Reset in the middle of a frame
    base = wlog.size(); p0 = act_pulses;
    for (int i = 0; i < 6; i++) pay[i] = 8'(8'h61 + i);
    model_frame(6, 6);
    send_byte(8'd6);
    send_byte(8'h61);
    send_byte(8'h62);
    rst_n = 1'b0;
    tick(1);
    exp_q.delete();
    exp_last.delete();
    exp_drops = 0;
    exp_pads = 0;
    exp_pulses = exp_pulses - 1;
    chk("mid_rst_ready", rx_ready, 1'b0);
    chk("mid_rst_write", SRAM_write, 1'b0);
    chk("mid_rst_data", Data_to_sram, 16'h0);
    chk("mid_rst_int", frame_recved_int, 1'b0);
    chk("mid_rst_drop", drop_count, 8'h0);
    chk("mid_rst_pad", pad_count, 8'h0);
    chk("mid_rst_words_kept", wlog.size() - base, 1);
    chk("mid_rst_w0", get_w(base), 16'h0661);
    rst_n = 1'b1;
    tick(1);
    chk("mid_rst_ready_rise", rx_ready, 1'b1);
    base = wlog.size();
    pay[0] = 8'h77;
    send_frame(1, 1);
    wait_drain("recover");
    chk("recover_w0", get_w(base), 16'h0177);
    chk("recover_pulses", act_pulses - p0, 1);

    chk("total_pulses", act_pulses, exp_pulses);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_frame_packer.md
# rx_frame_packer

Packs frames received from the radio byte stream into 16-bit words and writes them into the receive SRAM FIFO. The word layout is the one the CPU-side SPI controller unpacks for the 0x77 read command. Sits between the wireless receive path and the receive SRAM FIFO. Raises `frame_recved_int` once a complete frame is committed, which triggers the CPU interrupt.

## Interface
Parameters:
- `FIFO_DEPTH`, 2048: receive SRAM FIFO depth in 16-bit words.
- `TIMEOUT_CYC`, 50000: maximum idle cycles between bytes inside a frame.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: reset, synchronous, active-low.
- `rx_byte` in 8: byte from the radio receive path.
- `rx_valid` in 1: `rx_byte` is valid.
- `rx_ready` out 1: byte is accepted on a cycle where `rx_valid && rx_ready`.
- `SRAM_write` out 1: write request, held high until `SRAM_hint`.
- `SRAM_hint` in 1: FIFO acknowledges the access.
- `Data_to_sram` out 16: write word.
- `SRAM_full` in 1: FIFO full.
- `SRAM_count` in 11: current FIFO occupancy in words.
- `frame_recved_int` out 1: one-cycle pulse when a frame is committed.
- `drop_count` out 8: frames dropped for lack of space (statistics).
- `pad_count` out 8: frames truncated by timeout (statistics).

## Operation
- **Frame format in:** first byte is the length L (1..255), followed by L payload bytes b0..b(L-1).
- **Word format out:**
  - W0 = {L, b0}.
  - Then {b1,b2}, {b3,b4}, …, high byte first.
  - If L is even, the final low byte is 0x00.
  - Word count N = (L+2)>>1, computed in 9 bits.
- **States:**
  - IDLE: `rx_ready`=1.
    - L=0 is consumed and ignored; stay in IDLE.
    - L≠0 is latched; go to CHECK.
  - CHECK (1 cycle): free = FIFO_DEPTH − SRAM_count, 12-bit arithmetic.
    - free ≥ N → GET_HI.
    - Otherwise → DROP.
  - GET_HI / GET_LO: accept one byte into `Data_to_sram[15:8]` or `[7:0]`.
    - The first GET_HI uses the latched L as the high byte, so W0 only needs a GET_LO.
    - A word is ready when both halves are filled, or when the last payload byte lands in the high half (low half = 0x00).
    - A ready word goes to WR.
  - WR: wait for `!SRAM_full`, then assert `SRAM_write` → WAIT_HINT.
  - WAIT_HINT: on `SRAM_hint`, deassert `SRAM_write`.
    - Words remaining → GET_HI.
    - Otherwise → DONE.
  - DONE: pulse `frame_recved_int` for 1 cycle → IDLE.
  - DROP: `rx_ready`=1; consume L bytes with no FIFO writes; increment `drop_count` (saturating at 255) → IDLE. No interrupt.
  - PAD: entered when the timeout fires during GET_HI/GET_LO.
    - Fill the current word's unfilled bytes with 0x00.
    - Write all remaining words as 0x0000, so the FIFO framing stays consistent for the reader.
    - Increment `pad_count` (saturating) → IDLE. No interrupt.
- **Timeout counter:** clears on every accepted byte. Fires at TIMEOUT_CYC idle cycles while in GET_HI/GET_LO only.
- `rx_ready` = 1 only in IDLE, DROP, GET_HI and GET_LO.

## Timing
- **Reset values:** `rx_ready`=0, `SRAM_write`=0, `Data_to_sram`=0, `frame_recved_int`=0, `drop_count`=0, `pad_count`=0, state IDLE.
- **`rx_ready` after reset:** rises the cycle after `rst_n` deasserts.
- **Reset mid-frame:** returns to IDLE immediately. Words already written stay in the FIFO; recovery is the CPU driver's concern.
- **Write handshake:**
  - `SRAM_write` rises at most 1 cycle after the word is complete and `!SRAM_full`.
  - It falls the cycle after `SRAM_hint` is sampled high.
  - There is at least one low cycle between writes.
  - `Data_to_sram` is stable from `SRAM_write` rise until `SRAM_hint`.
- **Space check:** CHECK samples `SRAM_count` exactly once per frame.
  - The reader only removes words, so space cannot shrink afterwards.
  - `SRAM_full` is still honoured in WR.
- **Interrupt latency:** `frame_recved_int` is high the 2nd cycle after the last `SRAM_hint`.
- **Simultaneous events:** a byte offered in the same cycle the timeout fires is accepted, and the timeout is discarded.
- **Back-to-back frames:** a new length byte is accepted no earlier than the cycle after the DONE pulse.

## Configuration
- `RX_PACKER_STATS_EN`:
  - Defined: `drop_count` and `pad_count` are live saturating counters.
  - Undefined: both outputs are tied to 8'h00 and the counters are not synthesised. DROP and PAD behaviour is otherwise unchanged.

## Test plan
- L=3, bytes A1 A2 A3, empty FIFO → words 0x03A1, 0xA2A3; one `frame_recved_int` pulse; 2 writes total.
- L=4, bytes 11 22 33 44 → words 0x0411, 0x2233, 0x4400; one pulse.
- L=1, byte 5A → a single word 0x015A.
- L=0 → no write, no pulse, `rx_ready` stays 1.
- L=200 with `SRAM_count`=1950, FIFO_DEPTH=2048 (free 98 < N=101) → all 200 bytes consumed, 0 writes, `drop_count`=1, no pulse.
- L=5, bytes 01 02 03, then idle for TIMEOUT_CYC → words 0x0501, 0x0203, 0x0000; `pad_count`=1; no pulse.
- `SRAM_full` held for 10 cycles during a frame → `SRAM_write` stays low, then rises once `SRAM_full` drops.
- `rst_n` low mid-frame → all outputs return to their reset values, state IDLE.
